// File: rtl/ssd_scan.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered digit
// storage, anti-ghosting blanking at the start of each slot and leading-zero blanking.
module ssd_scan #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        ssd_scan_clk,
    input  logic        ssd_scan_rst,
    input  logic        ssd_scan_en,
    input  logic        ssd_scan_load,
    input  logic [31:0] ssd_scan_data,
    input  logic [7:0]  ssd_scan_dp,
    input  logic        ssd_scan_lzb,
    output logic [6:0]  ssd_scan_cc,
    output logic        ssd_scan_odp,
    output logic [7:0]  ssd_scan_an,
    output logic [2:0]  ssd_scan_digit,
    output logic        ssd_scan_frame,
    output logic [1:0]  ssd_scan_dbg_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] B_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // With no blank window a new slot starts lit straight away.
    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t         r_state;
    logic [PW-1:0]  r_presc;
    logic [2:0]     r_digit;

    logic [31:0]    r_pend_data;
    logic [7:0]     r_pend_dp;
    logic           r_pend_lzb;
    logic           r_pend_valid;
    logic [31:0]    r_disp_data;
    logic [7:0]     r_disp_dp;
    logic           r_disp_lzb;

    logic [7:0]     r_an;
    logic [6:0]     r_cc;
    logic           r_odp;
    logic           r_frame;

    state_t         w_state_nxt;
    logic [PW-1:0]  w_presc_nxt;
    logic [2:0]     w_digit_nxt;
    logic           w_frame_tc;
    logic           w_xfer;

    logic [31:0]    w_pend_data_nxt;
    logic [7:0]     w_pend_dp_nxt;
    logic           w_pend_lzb_nxt;
    logic           w_pend_valid_nxt;
    logic [31:0]    w_disp_data_nxt;
    logic [7:0]     w_disp_dp_nxt;
    logic           w_disp_lzb_nxt;

    logic [7:0]     w_tail_nz;
    logic           w_tail_acc;
    logic [3:0]     w_sel_nib;
    logic           w_suppress;
    logic [7:0]     w_an_nxt;
    logic [6:0]     w_cc_nxt;
    logic           w_odp_nxt;
    logic           w_frame_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Scan state machine: next state, prescaler and slot index.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_digit_nxt = r_digit;
        if (!ssd_scan_en) begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
            w_digit_nxt = 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SLOT_START;
                    w_presc_nxt = '0;
                    w_digit_nxt = 3'd0;
                end
                BLANK: begin
                    if (r_presc == B_LAST) begin
                        w_state_nxt = SHOW;
                    end
                    w_presc_nxt = r_presc + PW'(1);
                end
                SHOW: begin
                    if (r_presc == P_LAST) begin
                        w_state_nxt = SLOT_START;
                        w_presc_nxt = '0;
                        w_digit_nxt = r_digit + 3'd1;
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_presc_nxt = '0;
                    w_digit_nxt = 3'd0;
                end
            endcase
        end
    end

    assign w_frame_tc = (r_state == SHOW) && (r_digit == 3'd7) && (r_presc == P_LAST);
    assign w_xfer     = w_frame_tc || (r_state == IDLE);

    // Pending/display buffers: display only changes on a frame boundary or while idle.
    always_comb begin
        w_pend_data_nxt  = r_pend_data;
        w_pend_dp_nxt    = r_pend_dp;
        w_pend_lzb_nxt   = r_pend_lzb;
        w_pend_valid_nxt = r_pend_valid;
        w_disp_data_nxt  = r_disp_data;
        w_disp_dp_nxt    = r_disp_dp;
        w_disp_lzb_nxt   = r_disp_lzb;
        if (ssd_scan_load) begin
            w_pend_data_nxt = ssd_scan_data;
            w_pend_dp_nxt   = ssd_scan_dp;
            w_pend_lzb_nxt  = ssd_scan_lzb;
            if (w_xfer) begin
                w_disp_data_nxt  = ssd_scan_data;
                w_disp_dp_nxt    = ssd_scan_dp;
                w_disp_lzb_nxt   = ssd_scan_lzb;
                w_pend_valid_nxt = 1'b0;
            end else begin
                w_pend_valid_nxt = 1'b1;
            end
        end else if (w_xfer && r_pend_valid) begin
            w_disp_data_nxt  = r_pend_data;
            w_disp_dp_nxt    = r_pend_dp;
            w_disp_lzb_nxt   = r_pend_lzb;
            w_pend_valid_nxt = 1'b0;
        end
    end

    // w_tail_nz[k] is set when any nibble k..7 of the next display word is non-zero.
    always_comb begin
        w_tail_acc = 1'b0;
        w_tail_nz  = '0;
        for (int k = 7; k >= 0; k--) begin
            w_tail_acc   = w_tail_acc | (|w_disp_data_nxt[4*k +: 4]);
            w_tail_nz[k] = w_tail_acc;
        end
    end

    assign w_sel_nib  = w_disp_data_nxt[{w_digit_nxt, 2'b00} +: 4];
    assign w_suppress = w_disp_lzb_nxt && (w_digit_nxt != 3'd0) && !w_tail_nz[w_digit_nxt];

    // Outputs are decoded from next-cycle state so they line up with the state registers.
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_cc_nxt  = 7'h7F;
        w_odp_nxt = 1'b1;
        if ((w_state_nxt == SHOW) && !w_suppress) begin
            w_an_nxt  = ~(8'h01 << w_digit_nxt);
            w_cc_nxt  = seg_decode(w_sel_nib);
            w_odp_nxt = ~w_disp_dp_nxt[w_digit_nxt];
        end
        w_frame_nxt = w_frame_tc && ssd_scan_en;
    end

    always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst) begin
        if (!ssd_scan_rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_digit      <= 3'd0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_lzb   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_lzb   <= 1'b0;
            r_an         <= 8'hFF;
            r_cc         <= 7'h7F;
            r_odp        <= 1'b1;
            r_frame      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_digit      <= w_digit_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_pend_dp    <= w_pend_dp_nxt;
            r_pend_lzb   <= w_pend_lzb_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_disp_data  <= w_disp_data_nxt;
            r_disp_dp    <= w_disp_dp_nxt;
            r_disp_lzb   <= w_disp_lzb_nxt;
            r_an         <= w_an_nxt;
            r_cc         <= w_cc_nxt;
            r_odp        <= w_odp_nxt;
            r_frame      <= w_frame_nxt;
        end
    end

    assign ssd_scan_an        = r_an;
    assign ssd_scan_cc        = r_cc;
    assign ssd_scan_odp       = r_odp;
    assign ssd_scan_digit     = r_digit;
    assign ssd_scan_frame     = r_frame;
    assign ssd_scan_dbg_state = r_state;

endmodule

// File: tb/tb_ssd_scan.sv
// Bench for ssd_scan: every cycle is compared against a time-based model of the
// scan (cycles since enable -> slot/phase) with its own buffer bookkeeping.
module tb_ssd_scan;

    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 8 * P;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] cc;
        logic       odp;
        logic [2:0] digit;
        logic       frame;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [31:0] data  = '0;
    logic [7:0]  dp    = '0;
    logic        lzb   = 1'b0;
    logic [6:0]  cc;
    logic        odp;
    logic [7:0]  an;
    logic [2:0]  digit;
    logic        frame;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: idle flag, cycles since enable, and the two buffers.
    bit          m_idle;
    int          m_t;
    logic        m_frame;
    logic [31:0] m_pend_data, m_disp_data;
    logic [7:0]  m_pend_dp, m_disp_dp;
    logic        m_pend_lzb, m_disp_lzb, m_valid;

    ssd_scan #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .ssd_scan_clk      (clk),
        .ssd_scan_rst      (rst_n),
        .ssd_scan_en       (en),
        .ssd_scan_load     (load),
        .ssd_scan_data     (data),
        .ssd_scan_dp       (dp),
        .ssd_scan_lzb      (lzb),
        .ssd_scan_cc       (cc),
        .ssd_scan_odp      (odp),
        .ssd_scan_an       (an),
        .ssd_scan_digit    (digit),
        .ssd_scan_frame    (frame),
        .ssd_scan_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idle = 1'b1; m_t = 0; m_frame = 1'b0; m_valid = 1'b0;
        m_pend_data = '0; m_pend_dp = '0; m_pend_lzb = 1'b0;
        m_disp_data = '0; m_disp_dp = '0; m_disp_lzb = 1'b0;
    endtask

    task automatic model_edge();
        bit at_boundary, xfer;
        at_boundary = !m_idle && ((m_t % FRAME) == FRAME - 1);
        xfer        = m_idle || at_boundary;
        m_frame     = at_boundary && en;
        if (load && xfer) begin
            m_disp_data = data; m_disp_dp = dp; m_disp_lzb = lzb; m_valid = 1'b0;
        end else if (load) begin
            m_pend_data = data; m_pend_dp = dp; m_pend_lzb = lzb; m_valid = 1'b1;
        end else if (xfer && m_valid) begin
            m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_disp_lzb = m_pend_lzb;
            m_valid = 1'b0;
        end
        if (!en) begin
            m_idle = 1'b1; m_t = 0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        int slot, phase;
        logic [31:0] tail;
        logic [3:0] nib;
        bit sup;
        e.an = 8'hFF; e.cc = 7'h7F; e.odp = 1'b1; e.digit = 3'd0; e.frame = m_frame;
        if (!m_idle) begin
            slot    = (m_t / P) % 8;
            phase   = m_t % P;
            e.digit = slot[2:0];
            tail    = m_disp_data >> (4 * slot);
            nib     = tail[3:0];
            sup     = m_disp_lzb && (slot != 0) && (tail == 32'd0);
            if (phase >= B && !sup) begin
                e.an  = ~(8'h01 << slot);
                e.cc  = seg_tab[nib];
                e.odp = ~m_disp_dp[slot];
            end
        end
        return e;
    endfunction

    task automatic check(input string tag);
        obs_t o, e;
        o = {an, cc, odp, digit, frame};
        e = model_out();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s t=%0d: got an=%h cc=%b odp=%b digit=%0d frame=%b, expected an=%h cc=%b odp=%b digit=%0d frame=%b",
                   tag, m_t, o.an, o.cc, o.odp, o.digit, o.frame, e.an, e.cc, e.odp, e.digit, e.frame);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle");
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic l);
        data = d; dp = p; lzb = l; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advances until the model sits in a lit phase of the given slot (-1: any slot).
    task automatic wait_lit(input int slot, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            if (!m_idle && (m_t % P) >= B && (slot < 0 || ((m_t / P) % 8) == slot)) hit = 1'b1;
            else tick();
        end
        n_tests++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL %s: lit slot not reached, got none, expected slot %0d", tag, slot);
        end
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_async");
        @(posedge clk); #1 check("reset_held");
        #2 rst_n = 1'b1;

        // Small value with leading-zero blanking, loaded while idle.
        do_load(32'h0000_0012, 8'h00, 1'b1);
        en = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k == 1)  expect_val("blank_slot0_an", {24'd0, an}, 32'hFE ^ 32'h01);
            if (k == 3)  expect_val("slot0_lit", {17'd0, an, cc}, {17'd0, 8'hFE, 7'b0100100});
            if (k == 11) expect_val("slot1_lit", {17'd0, an, cc}, {17'd0, 8'hFD, 7'b1111001});
            if (k == 19) expect_val("slot2_lzb", {24'd0, an}, 32'hFF);
            if (k == 65) expect_val("frame_pulse", {31'd0, frame}, 32'd1);
        end

        // All eights with a single decimal point; takes effect at next frame.
        do_load(32'h8888_8888, 8'h01, 1'b0);
        run(140);

        // Mid-frame load must wait for the frame boundary.
        do_load(32'h0000_0000, 8'h00, 1'b0);
        run(70);
        wait_lit(3, "wait_slot3");
        do_load(32'h1111_1111, 8'h00, 1'b0);
        expect_val("no_early_swap", {25'd0, cc}, {25'd0, 7'b1000000});
        run(140);

        // Enable dropped during slot 5 while lit.
        wait_lit(5, "wait_slot5");
        en = 1'b0;
        tick();
        expect_val("drop_en", {20'd0, an, digit, frame}, {20'd0, 8'hFF, 3'd0, 1'b0});
        en = 1'b1;
        run(2);
        expect_val("reenable_blank", {24'd0, an}, 32'hFF);
        tick();
        expect_val("reenable_lit", {24'd0, an}, 32'hFE);

        // Randomised loads and enable toggles.
        for (int i = 0; i < 900; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                data = $urandom() >> (4 * $urandom_range(0, 8));
                dp   = 8'($urandom());
                lzb  = 1'($urandom());
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (en && r == 99) en = 1'b0;
            else if (!en && r > 70) en = 1'b1;
            tick();
        end
        load = 1'b0;
        en   = 1'b1;

        // Asynchronous reset while lit, with a pending load outstanding.
        wait_lit(-1, "wait_any");
        do_load(32'hABCD_1234, 8'hFF, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("reset_mid_show");
        @(posedge clk); #1 check("reset_mid_held");
        #2 rst_n = 1'b1;
        run(FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
